seven_seg_scan_decoder: RTL and testbench
=========================================

Name: seven_seg_scan_decoder

Overview:
Reader side of the seven-segment display path. It samples a multiplexed, active-low segment bus together with its active-low digit-enable strobes and recovers the hex nibble and decimal point for each digit. It detects invalid glyphs and reports when a full frame of digits has been captured. It is used for display loopback checking and for board self-test, and sits between the display pins and the test/status logic.

Parameters:
NUM_DIGITS, 8, number of scanned digits (2..8)
STABLE_CYCLES, 4, consecutive unchanged registered samples required before a digit is captured (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
seg_in  input  8  segment bus, active-low; bit7 = dp, bits6:0 = g..a
an_in  input  NUM_DIGITS  digit enables, active-low, one-hot-low when valid
err_clear  input  1  clears pattern_err and err_digit
value_out  output  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i]
dp_out  output  NUM_DIGITS  decoded decimal points, active-high
digit_valid  output  NUM_DIGITS  bit i = last capture of digit i decoded cleanly
frame_valid  output  1  one-cycle pulse when every digit has been captured since the last pulse
pattern_err  output  1  sticky flag: an unrecognised glyph was captured
err_digit  output  3  index of the most recent bad digit

Behaviour:
- Reset (synchronous, active-high): all outputs go to 0. This includes value_out, dp_out, digit_valid, frame_valid, pattern_err and err_digit. The input register, stability counter and seen mask are also cleared. A reset asserted mid-dwell discards the partial count.
- Stage 1 registers seg_in and an_in every cycle. This is the only synchroniser; the pins are treated as already synchronous.
- an_in is valid only when exactly one bit is 0. If it is not valid (all 1s or more than one 0), the counter resets to 0 and no capture occurs.
- The stability counter increments while the registered {an, seg} pair equals the previous registered pair and an is valid. It saturates at STABLE_CYCLES. Any change resets it to 1 if the new an is valid, otherwise to 0.
- A capture fires exactly once per dwell, on the edge where the counter transitions to STABLE_CYCLES. A new capture needs a change followed by another full dwell.
- Latency: a pair first registered at edge E is captured at edge E+STABLE_CYCLES. Outputs are visible after that edge.
- Capture of digit i (the index of the low an bit):
  - dp_out[i] = ~seg[7].
  - seg[6:0] is inverse-decoded with the standard active-low hex glyph set. The 0..F glyphs are: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E, given with dp=1, so compare bits 6:0 only.
  - On a match: value_out[4i+3:4i] = nibble and digit_valid[i] = 1.
  - On no match: value_out for digit i is held, digit_valid[i] = 0, pattern_err = 1, err_digit = i.
  - Either way, seen[i] = 1.
- Frame: on the edge where seen becomes all-ones, frame_valid pulses high for one cycle and seen clears to 0. The capture that completes the frame is counted in that frame.
- err_clear clears pattern_err and err_digit on the next edge. If a bad capture occurs in the same cycle, the new error wins: the flag stays set and err_digit is updated.
- Digits with index ≥ NUM_DIGITS do not exist. err_digit is zero-extended.

Optional Feature:
SEVEN_SEG_BLANK_EN
- Defined: seg[6:0] = 7F (all segments off) is a legal blank glyph. Capture sets digit_valid[i] = 0, holds value_out, does not raise pattern_err, and still sets seen[i].
- Undefined: 7F is an unrecognised glyph and sets pattern_err like any other mismatch.

Test Plan:
- Reset release, an_in=FF, seg_in=FF for 20 cycles -> all outputs 0, no frame_valid, no pattern_err.
- STABLE_CYCLES=4; an_in=FE, seg_in=A4 applied before edge 0 and held -> value_out[3:0]=2, digit_valid[0]=1 after edge 4 and not before; dp_out[0]=0.
- Scan 8 digits at 6 cycles each, glyphs 0..7 -> value_out=76543210, exactly one frame_valid pulse on the 8th capture; a second full scan gives a second pulse.
- an_in=FB, seg_in=FF (undefined macro), then err_clear pulse -> pattern_err=1, err_digit=2 at capture; both 0 after the clear. Re-run with SEVEN_SEG_BLANK_EN defined -> pattern_err stays 0 and digit_valid[2]=0.
- Glitch: an_in=FD, seg_in=F9 held 3 cycles, seg_in changes for 1 cycle, then returns -> no capture until 4 further stable cycles; then value_out[7:4]=1. an_in=FC (two digits low) -> no capture.
- reset asserted at count 3 of a dwell, then released with the pair held -> capture occurs STABLE_CYCLES edges after release; err_clear coincident with a bad capture -> pattern_err remains 1.

Source files
------------

// File: rtl/seven_seg_scan_decoder.sv
// Recovers hex nibbles and decimal points from a scanned, active-low seven-segment bus.
// Define SEVEN_SEG_BLANK_EN to accept the all-segments-off glyph as a legal blank digit.
module seven_seg_scan_decoder #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    err_clear,
    output logic [4*NUM_DIGITS-1:0] value_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    output logic                    pattern_err,
    output logic [2:0]              err_digit
);

    localparam int            CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [7:0]            seg_q, seg_p;
    logic [NUM_DIGITS-1:0] an_q, an_p;
    logic [CW-1:0]         cnt;
    logic [NUM_DIGITS-1:0] seen;

    logic                  an_ok;
    logic [3:0]            low_cnt;
    logic [2:0]            cur_idx;
    logic                  pair_same;
    logic [CW-1:0]         cnt_next;
    logic                  capture;
    logic                  glyph_hit;
    logic [3:0]            glyph_nib;
    logic                  glyph_blank;
    logic                  glyph_bad;
    logic [NUM_DIGITS-1:0] seen_next;
    logic                  frame_done;

    // NOTE: every signal written in an always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        low_cnt = 4'd0;
        cur_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_q[i]) begin
                low_cnt = low_cnt + 4'd1;
                cur_idx = 3'(i);
            end
        end
        an_ok = (low_cnt == 4'd1);
    end

    // Inverse of the standard active-low hex glyph set; the dp bit is ignored.
    always_comb begin
        glyph_hit = 1'b1;
        glyph_nib = 4'h0;
        case (seg_q[6:0])
            7'h40:   glyph_nib = 4'h0;
            7'h79:   glyph_nib = 4'h1;
            7'h24:   glyph_nib = 4'h2;
            7'h30:   glyph_nib = 4'h3;
            7'h19:   glyph_nib = 4'h4;
            7'h12:   glyph_nib = 4'h5;
            7'h02:   glyph_nib = 4'h6;
            7'h78:   glyph_nib = 4'h7;
            7'h00:   glyph_nib = 4'h8;
            7'h10:   glyph_nib = 4'h9;
            7'h08:   glyph_nib = 4'hA;
            7'h03:   glyph_nib = 4'hB;
            7'h46:   glyph_nib = 4'hC;
            7'h21:   glyph_nib = 4'hD;
            7'h06:   glyph_nib = 4'hE;
            7'h0E:   glyph_nib = 4'hF;
            default: glyph_hit = 1'b0;
        endcase
    end

`ifdef SEVEN_SEG_BLANK_EN
    assign glyph_blank = (seg_q[6:0] == 7'h7F);
`else
    assign glyph_blank = 1'b0;
`endif

    assign glyph_bad = !glyph_hit && !glyph_blank;
    assign pair_same = (an_q == an_p) && (seg_q == seg_p);

    always_comb begin
        if (!an_ok)
            cnt_next = '0;
        else if (!pair_same)
            cnt_next = CW'(1);
        else if (cnt == CNT_MAX)
            cnt_next = cnt;
        else
            cnt_next = cnt + CW'(1);
    end

    // The "changed" term keeps STABLE_CYCLES=1 capturing once per new pair.
    assign capture    = an_ok && (cnt_next == CNT_MAX) && (!pair_same || (cnt != CNT_MAX));
    assign seen_next  = seen | ({NUM_DIGITS{capture}} & ~an_q);
    assign frame_done = capture && (&seen_next);

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= '0;
            an_q        <= '0;
            seg_p       <= '0;
            an_p        <= '0;
            cnt         <= '0;
            seen        <= '0;
            value_out   <= '0;
            dp_out      <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            err_digit   <= 3'd0;
        end else begin
            seg_q       <= seg_in;
            an_q        <= an_in;
            seg_p       <= seg_q;
            an_p        <= an_q;
            cnt         <= cnt_next;
            frame_valid <= frame_done;
            seen        <= frame_done ? '0 : seen_next;

            if (capture) begin
                dp_out[cur_idx]      <= ~seg_q[7];
                digit_valid[cur_idx] <= glyph_hit;
                if (glyph_hit)
                    value_out[{cur_idx, 2'b00} +: 4] <= glyph_nib;
            end

            // A bad capture outranks a simultaneous clear.
            if (capture && glyph_bad) begin
                pattern_err <= 1'b1;
                err_digit   <= cur_idx;
            end else if (err_clear) begin
                pattern_err <= 1'b0;
                err_digit   <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Self-checking bench for seven_seg_scan_decoder: directed scenarios plus randomized
// scanning, all compared against a dwell/run-length reference model.
module tb_seven_seg_scan_decoder;

    localparam int ND = 8;
    localparam int SC = 4;
    localparam int VW = 4*ND + 2*ND + 5;

`ifdef SEVEN_SEG_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    localparam logic [7:0] GLYPH_TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      seg_in;
    logic [ND-1:0]   an_in;
    logic            err_clear;
    logic [4*ND-1:0] value_out;
    logic [ND-1:0]   dp_out;
    logic [ND-1:0]   digit_valid;
    logic            frame_valid;
    logic            pattern_err;
    logic [2:0]      err_digit;
    logic [VW-1:0]   dut_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .err_clear   (err_clear),
        .value_out   (value_out),
        .dp_out      (dp_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .pattern_err (pattern_err),
        .err_digit   (err_digit)
    );

    assign dut_vec = {value_out, dp_out, digit_valid, frame_valid, pattern_err, err_digit};

    // Reference model: a capture is due one edge after the same valid pair has been
    // applied for SC consecutive edges.
    int            m_value [ND];
    bit            m_dp    [ND];
    bit            m_dv    [ND];
    bit            m_seen  [ND];
    bit            m_fv;
    bit            m_err;
    int            m_errd;
    logic [ND-1:0] prev_an;
    logic [7:0]    prev_seg;
    int            run;
    bit            pend;
    logic [ND-1:0] pend_an;
    logic [7:0]    pend_seg;

    function automatic int low_count(input logic [ND-1:0] an);
        int n = 0;
        for (int i = 0; i < ND; i++)
            if (an[i] == 1'b0) n++;
        return n;
    endfunction

    function automatic int low_index(input logic [ND-1:0] an);
        int idx = 0;
        for (int i = 0; i < ND; i++)
            if (an[i] == 1'b0) idx = i;
        return idx;
    endfunction

    function automatic int glyph_value(input logic [7:0] s);
        int v = -1;
        logic [7:0] g;
        for (int n = 0; n < 16; n++) begin
            g = GLYPH_TBL[n];
            if (g[6:0] == s[6:0]) v = n;
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [4*ND-1:0] v;
        logic [ND-1:0]   d;
        logic [ND-1:0]   q;
        for (int i = 0; i < ND; i++) begin
            v[4*i +: 4] = 4'(m_value[i]);
            d[i] = m_dp[i];
            q[i] = m_dv[i];
        end
        return {v, d, q, m_fv, m_err, 3'(m_errd)};
    endfunction

    task automatic model_edge();
        int  idx;
        int  nib;
        bit  bad;
        bit  all_seen;
        idx = 0;
        bad = 1'b0;
        if (reset) begin
            for (int i = 0; i < ND; i++) begin
                m_value[i] = 0; m_dp[i] = 0; m_dv[i] = 0; m_seen[i] = 0;
            end
            m_fv = 0; m_err = 0; m_errd = 0;
            prev_an = '0; prev_seg = '0; run = 0; pend = 0;
            return;
        end
        m_fv = 1'b0;
        if (pend) begin
            idx = low_index(pend_an);
            nib = glyph_value(pend_seg);
            m_dp[idx] = !pend_seg[7];
            if (nib >= 0) begin
                m_value[idx] = nib;
                m_dv[idx]    = 1'b1;
            end else begin
                m_dv[idx] = 1'b0;
                bad = !(BLANK && pend_seg[6:0] == 7'h7F);
            end
            m_seen[idx] = 1'b1;
            all_seen = 1'b1;
            for (int i = 0; i < ND; i++)
                if (!m_seen[i]) all_seen = 1'b0;
            if (all_seen) begin
                m_fv = 1'b1;
                for (int i = 0; i < ND; i++) m_seen[i] = 1'b0;
            end
        end
        if (bad) begin
            m_err = 1'b1; m_errd = idx;
        end else if (err_clear) begin
            m_err = 1'b0; m_errd = 0;
        end
        pend = 1'b0;
        if (an_in == prev_an && seg_in == prev_seg)
            run = (run < 1000) ? run + 1 : run;
        else
            run = 1;
        prev_an  = an_in;
        prev_seg = seg_in;
        if (run == SC && low_count(an_in) == 1) begin
            pend = 1'b1; pend_an = an_in; pend_seg = seg_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; an_in = '1; seg_in = 8'hFF; err_clear = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (dut_vec !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h expected 0", c, dut_vec);
            end
        end
    endtask

    task automatic test_latency();
        an_in = 8'hFE; seg_in = 8'hA4;
        for (int e = 0; e <= 4; e++) begin
            tick();
            checks++;
            if (digit_valid[0] !== (e == 4) || value_out[3:0] !== ((e == 4) ? 4'h2 : 4'h0)
                || dp_out[0] !== 1'b0) begin
                errors++;
                $display("FAIL latency edge %0d: got dv=%b val=%h dp=%b", e,
                         digit_valid[0], value_out[3:0], dp_out[0]);
            end
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL latency_model edge %0d: got %h expected %h", e, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_scan();
        int fv_count;
        int g;
        do_reset();
        fv_count = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int d = 0; d < ND; d++) begin
                an_in = ~(ND'(1) << d);
                if (pass == 0) begin
                    seg_in = GLYPH_TBL[d];
                end else begin
                    g = int'($urandom_range(0, 15));
                    seg_in = GLYPH_TBL[g];
                    seg_in[7] = 1'($urandom_range(0, 1));
                end
                for (int c = 0; c < 6; c++) begin
                    tick();
                    if (frame_valid === 1'b1) fv_count++;
                    checks++;
                    if (dut_vec !== model_vec()) begin
                        errors++;
                        $display("FAIL scan_model pass %0d digit %0d: got %h expected %h",
                                 pass, d, dut_vec, model_vec());
                    end
                end
            end
            if (pass == 0) begin
                checks++;
                if (value_out !== 32'h76543210 || dp_out !== '0 || digit_valid !== '1) begin
                    errors++;
                    $display("FAIL scan_values: got %h dp=%h dv=%h expected 76543210 00 ff",
                             value_out, dp_out, digit_valid);
                end
            end
            checks++;
            if (fv_count !== pass + 1) begin
                errors++;
                $display("FAIL scan_frames pass %0d: got %0d pulses expected %0d",
                         pass, fv_count, pass + 1);
            end
        end
    endtask

    task automatic test_error();
        an_in = 8'hFB; seg_in = 8'hFF;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL error_model cycle %0d: got %h expected %h", c, dut_vec, model_vec());
            end
        end
        checks++;
        if (pattern_err !== !BLANK || err_digit !== (BLANK ? 3'd0 : 3'd2) || digit_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL error_capture: got err=%b digit=%0d dv2=%b", pattern_err, err_digit,
                     digit_valid[2]);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (pattern_err !== 1'b0 || err_digit !== 3'd0) begin
            errors++;
            $display("FAIL error_clear: got err=%b digit=%0d expected 0 0", pattern_err, err_digit);
        end
    endtask

    task automatic test_glitch();
        an_in = 8'hFD; seg_in = 8'h88;
        repeat (6) tick();
        seg_in = 8'hF9;
        repeat (3) tick();
        seg_in = 8'hA4;
        tick();
        seg_in = 8'hF9;
        for (int t = 1; t <= 5; t++) begin
            tick();
            checks++;
            if (value_out[7:4] !== ((t == 5) ? 4'h1 : 4'hA)) begin
                errors++;
                $display("FAIL glitch_dwell tick %0d: got %h expected %h", t, value_out[7:4],
                         (t == 5) ? 4'h1 : 4'hA);
            end
        end
        an_in = 8'hFC; seg_in = 8'hC0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (dut_vec !== model_vec() || value_out[7:4] !== 4'h1) begin
                errors++;
                $display("FAIL two_low cycle %0d: got %h expected %h", c, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_reset_mid_dwell();
        an_in = 8'hF7; seg_in = 8'h99;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL mid_dwell_reset: got %h expected 0", dut_vec);
        end
        for (int t = 1; t <= 5; t++) begin
            tick();
            checks++;
            if (digit_valid[3] !== (t == 5) || value_out[15:12] !== ((t == 5) ? 4'h4 : 4'h0)) begin
                errors++;
                $display("FAIL mid_dwell_capture tick %0d: got dv=%b val=%h", t, digit_valid[3],
                         value_out[15:12]);
            end
        end
        an_in = 8'hEF; seg_in = 8'hFE;
        repeat (4) tick();
        checks++;
        if (pattern_err !== 1'b0) begin
            errors++;
            $display("FAIL coincident_pre: got err=%b expected 0", pattern_err);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (pattern_err !== 1'b1 || err_digit !== 3'd4) begin
            errors++;
            $display("FAIL coincident_clear: got err=%b digit=%0d expected 1 4", pattern_err, err_digit);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (pattern_err !== 1'b0 || err_digit !== 3'd0) begin
            errors++;
            $display("FAIL coincident_after: got err=%b digit=%0d expected 0 0", pattern_err, err_digit);
        end
    endtask

    task automatic test_random();
        int dwell;
        int g;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0)
                an_in = ND'($urandom);
            else
                an_in = ~(ND'(1) << $urandom_range(0, ND - 1));
            case ($urandom_range(0, 5))
                0:       seg_in = 8'($urandom);
                1:       seg_in = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h7F;
                default: begin
                    g = int'($urandom_range(0, 15));
                    seg_in = GLYPH_TBL[g];
                    seg_in[7] = 1'($urandom_range(0, 1));
                end
            endcase
            dwell = int'($urandom_range(1, 8));
            for (int c = 0; c < dwell; c++) begin
                err_clear = ($urandom_range(0, 15) == 0);
                reset     = ($urandom_range(0, 199) == 0);
                tick();
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL random step %0d: got %h expected %h", k, dut_vec, model_vec());
                end
            end
            err_clear = 1'b0;
            reset     = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; an_in = '1; seg_in = 8'hFF; err_clear = 1'b0;
        test_reset();
        test_latency();
        test_scan();
        test_error();
        test_glitch();
        test_reset_mid_dwell();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
